ps2_rx_fifo: RTL and testbench

- Next-generation PS/2 receiver, fully synchronous to the system clock.
- Oversamples the PS/2 clock and data lines, glitch-filters the clock and decodes 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
- Checks parity and stop bit, then buffers good bytes in a parametrised first-word-fall-through FIFO.
- Sits between the PS/2 pins and the keyboard scan-code decoder; replaces the earlier PS/2-clock-edge-driven receiver.

---
 rtl/ps2_rx_fifo_if.sv | 26 ++
 rtl/ps2_rx_fifo.sv | 198 +++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_fifo_if.sv
// rtl/ps2_rx_fifo_if.sv - read-side and status bundle of the PS/2 receive FIFO
interface ps2_rx_fifo_if #(
   parameter int FIFO_DEPTH = 8
);
   logic                        i_rd_en;
   logic [7:0]                  o_rd_data;
   logic                        o_empty;
   logic                        o_full;
   logic [$clog2(FIFO_DEPTH):0] o_count;
   logic                        o_parity_err;
   logic                        o_frame_err;
   logic                        o_overflow;
   logic                        o_busy;

   modport master (
      output i_rd_en,
      input  o_rd_data, o_empty, o_full, o_count,
      input  o_parity_err, o_frame_err, o_overflow, o_busy
   );

   modport slave (
      input  i_rd_en,
      output o_rd_data, o_empty, o_full, o_count,
      output o_parity_err, o_frame_err, o_overflow, o_busy
   );
endinterface

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - oversampled PS/2 frame receiver feeding a first-word-fall-through byte FIFO
// Optional in-frame inactivity timeout enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_fifo #(
   parameter int FIFO_DEPTH     = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_ps2_clk,
   input  logic         i_ps2_data,
   ps2_rx_fifo_if.slave rx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_s;
   logic                   bit_in;
   logic [FW-1:0]          filt_cnt;
   logic                   filt_clk;
   logic                   filt_clk_q;
   logic                   fall;

   state_t     state, state_d;
   logic [2:0] bit_cnt, bit_cnt_d;
   logic [7:0] shreg, shreg_d;
   logic       par_bit, par_d;
   logic       wr_req;
   logic       perr_d, ferr_d;
   logic       tmo_hit;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          empty, full, do_rd, do_wr;
   logic          parity_err_q, frame_err_q, overflow_q;

   // Idle PS/2 lines are high, so the synchronisers reset to 1 as well
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         clk_sync  <= '1;
         data_sync <= '1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], i_ps2_data};
      end
   end

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign bit_in = data_sync[SYNC_STAGES-1];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         filt_cnt   <= '0;
         filt_clk   <= 1'b1;
         filt_clk_q <= 1'b1;
      end else begin
         filt_clk_q <= filt_clk;
         if (clk_s == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_s;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign fall = filt_clk_q & ~filt_clk;

`ifdef PS2_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         tmo_cnt <= '0;
      else if (fall || state == ST_IDLE)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo_hit = (state != ST_IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign tmo_hit        = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else begin
         state   <= state_d;
         bit_cnt <= bit_cnt_d;
         shreg   <= shreg_d;
         par_bit <= par_d;
      end
   end

   // An edge always wins over a coincident timeout
   always_comb begin
      state_d   = state;
      bit_cnt_d = bit_cnt;
      shreg_d   = shreg;
      par_d     = par_bit;
      wr_req    = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      if (fall) begin
         case (state)
            ST_IDLE: begin
               if (!bit_in) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end
            end
            ST_DATA: begin
               shreg_d[bit_cnt] = bit_in;
               bit_cnt_d        = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7)
                  state_d = ST_PARITY;
            end
            ST_PARITY: begin
               par_d   = bit_in;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (!bit_in)
                  ferr_d = 1'b1;
               else if (!(^{shreg, par_bit}))
                  perr_d = 1'b1;
               else
                  wr_req = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (tmo_hit) begin
         state_d = ST_IDLE;
         ferr_d  = 1'b1;
      end
   end

   assign empty = (count == '0);
   assign full  = (count == CW'(FIFO_DEPTH));
   assign do_rd = rx.i_rd_en & ~empty;
   assign do_wr = wr_req & (~full | do_rd);

   always_ff @(posedge i_clk) begin
      if (do_wr)
         mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         if (do_wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_rd)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         parity_err_q <= perr_d;
         frame_err_q  <= ferr_d;
         overflow_q   <= wr_req & ~do_wr;
      end
   end

   assign rx.o_rd_data    = empty ? 8'h00 : mem[rd_ptr];
   assign rx.o_empty      = empty;
   assign rx.o_full       = full;
   assign rx.o_count      = count;
   assign rx.o_parity_err = parity_err_q;
   assign rx.o_frame_err  = frame_err_q;
   assign rx.o_overflow   = overflow_q;
   assign rx.o_busy       = (state != ST_IDLE);
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - self-checking bench for ps2_rx_fifo
`timescale 1ns/1ps
module tb_ps2_rx_fifo;
   localparam int DEPTH = 8;
   localparam int SYNC  = 2;
   localparam int FILT  = 4;
   localparam int TMO   = 300;
   localparam int HALF  = 10;
   localparam int LAT   = SYNC + FILT + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;

   always #5 clk = ~clk;

   ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

   ps2_rx_fifo #(
      .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data), .rx(bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int perr_cnt = 0;
   int ferr_cnt = 0;
   int ovf_cnt  = 0;

   always @(negedge clk) begin
      if (bus.o_parity_err === 1'b1) perr_cnt++;
      if (bus.o_frame_err === 1'b1)  ferr_cnt++;
      if (bus.o_overflow === 1'b1)   ovf_cnt++;
   end

   function automatic logic odd_par(input logic [7:0] d);
      return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
   endfunction

   task automatic send_bit(input logic b);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit pop_on_write);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(par);
      ps2_data = stop;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_on_write) begin
         repeat (SYNC + FILT) @(negedge clk);
         bus.i_rd_en = 1'b1;
         @(negedge clk);
         bus.i_rd_en = 1'b0;
         repeat (HALF - SYNC - FILT - 1) @(negedge clk);
      end else begin
         repeat (HALF) @(negedge clk);
      end
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic pop(output logic [7:0] d, output logic was_empty);
      d         = bus.o_rd_data;
      was_empty = bus.o_empty;
      bus.i_rd_en = 1'b1;
      @(negedge clk);
      bus.i_rd_en = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.o_empty); end
      n_checks++; if (bus.o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.o_full); end
      n_checks++; if (bus.o_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.o_count); end
      n_checks++; if (bus.o_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %02h want 00", bus.o_rd_data); end
      n_checks++; if ({bus.o_parity_err, bus.o_frame_err, bus.o_overflow} !== 3'b000) begin
         n_fail++; $display("FAIL reset_pulses: got %b want 000", {bus.o_parity_err, bus.o_frame_err, bus.o_overflow}); end
      n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_latency;
      int p0 = perr_cnt, f0 = ferr_cnt, o0 = ovf_cnt;
      int lat = -1;
      logic [7:0] d; logic e;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d_of(8'h1C, i));
      send_bit(odd_par(8'h1C));
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk); #1;
         if (bus.o_empty === 1'b0) begin lat = n; break; end
      end
      n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL latency: got %0d cycles want %0d", lat, LAT); end
      @(negedge clk);
      repeat (HALF - 1) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      n_checks++; if (bus.o_rd_data !== 8'h1C) begin n_fail++; $display("FAIL latency_data: got %02h want 1c", bus.o_rd_data); end
      n_checks++; if (bus.o_count !== 4'd1) begin n_fail++; $display("FAIL latency_count: got %0d want 1", bus.o_count); end
      n_checks++; if ((perr_cnt - p0) + (ferr_cnt - f0) + (ovf_cnt - o0) != 0) begin
         n_fail++; $display("FAIL latency_pulses: got %0d pulses want 0", (perr_cnt - p0) + (ferr_cnt - f0) + (ovf_cnt - o0)); end
      pop(d, e);
      n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL latency_drain: empty got %b want 1", bus.o_empty); end
   endtask

   function automatic logic d_of(input logic [7:0] v, input int i);
      return v[i];
   endfunction

   task automatic test_two_frames_glitch;
      logic [7:0] d; logic e;
      send_frame(8'hF0, odd_par(8'hF0), 1'b1, 1'b0);
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2_data = 1'b1;
      n_checks++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b want 0", bus.o_busy); end
      send_frame(8'h1C, odd_par(8'h1C), 1'b1, 1'b0);
      n_checks++; if (bus.o_count !== 4'd2) begin n_fail++; $display("FAIL two_count: got %0d want 2", bus.o_count); end
      pop(d, e);
      n_checks++; if (e !== 1'b0 || d !== 8'hF0) begin n_fail++; $display("FAIL two_pop1: got %02h empty=%b want f0", d, e); end
      pop(d, e);
      n_checks++; if (e !== 1'b0 || d !== 8'h1C) begin n_fail++; $display("FAIL two_pop2: got %02h empty=%b want 1c", d, e); end
      n_checks++; if (bus.o_empty !== 1'b1 || bus.o_count !== '0) begin
         n_fail++; $display("FAIL two_after: empty=%b count=%0d want 1/0", bus.o_empty, bus.o_count); end
   endtask

   task automatic test_errors;
      int p0 = perr_cnt, f0 = ferr_cnt;
      send_frame(8'h1C, ~odd_par(8'h1C), 1'b1, 1'b0);
      n_checks++; if (perr_cnt - p0 != 1 || ferr_cnt - f0 != 0) begin
         n_fail++; $display("FAIL parity_err: got perr=%0d ferr=%0d want 1/0", perr_cnt - p0, ferr_cnt - f0); end
      n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL parity_empty: got %b want 1", bus.o_empty); end
      p0 = perr_cnt; f0 = ferr_cnt;
      send_frame(8'h1C, odd_par(8'h1C), 1'b0, 1'b0);
      n_checks++; if (ferr_cnt - f0 != 1 || perr_cnt - p0 != 0) begin
         n_fail++; $display("FAIL frame_err: got ferr=%0d perr=%0d want 1/0", ferr_cnt - f0, perr_cnt - p0); end
      n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL frame_empty: got %b want 1", bus.o_empty); end
   endtask

   task automatic test_overflow;
      int o0;
      logic [7:0] d; logic e;
      for (int k = 1; k <= 8; k++) send_frame(8'(k), odd_par(8'(k)), 1'b1, 1'b0);
      n_checks++; if (bus.o_full !== 1'b1 || bus.o_count !== 4'd8) begin
         n_fail++; $display("FAIL ovf_full: full=%b count=%0d want 1/8", bus.o_full, bus.o_count); end
      o0 = ovf_cnt;
      send_frame(8'h09, odd_par(8'h09), 1'b1, 1'b0);
      n_checks++; if (ovf_cnt - o0 != 1 || bus.o_count !== 4'd8) begin
         n_fail++; $display("FAIL ovf_pulse: pulses=%0d count=%0d want 1/8", ovf_cnt - o0, bus.o_count); end
      for (int k = 1; k <= 8; k++) begin
         pop(d, e);
         n_checks++; if (e !== 1'b0 || d !== 8'(k)) begin n_fail++; $display("FAIL ovf_read%0d: got %02h empty=%b want %02h", k, d, e, k); end
      end
      n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drain: empty got %b want 1", bus.o_empty); end
   endtask

   task automatic test_full_read_write;
      int o0;
      logic [7:0] d; logic e;
      for (int k = 1; k <= 8; k++) send_frame(8'(k), odd_par(8'(k)), 1'b1, 1'b0);
      o0 = ovf_cnt;
      send_frame(8'h09, odd_par(8'h09), 1'b1, 1'b1);
      n_checks++; if (ovf_cnt - o0 != 0 || bus.o_count !== 4'd8) begin
         n_fail++; $display("FAIL frw_count: pulses=%0d count=%0d want 0/8", ovf_cnt - o0, bus.o_count); end
      for (int k = 2; k <= 9; k++) begin
         pop(d, e);
         n_checks++; if (e !== 1'b0 || d !== 8'(k)) begin n_fail++; $display("FAIL frw_read%0d: got %02h empty=%b want %02h", k, d, e, k); end
      end
   endtask

   task automatic test_random;
      logic [7:0] model[$];
      logic [7:0] d, x; logic e, par, stop;
      int p0, f0, o0, kind, np;
      int exp_p, exp_f, exp_o;
      for (int it = 0; it < 30; it++) begin
         np = $urandom_range(0, 2);
         for (int j = 0; j < np && model.size() > 0; j++) begin
            x = model.pop_front();
            pop(d, e);
            n_checks++; if (e !== 1'b0 || d !== x) begin n_fail++; $display("FAIL rand_pop%0d: got %02h empty=%b want %02h", it, d, e, x); end
         end
         d = 8'($urandom);
         kind = $urandom_range(0, 5);
         stop = (kind == 1) ? 1'b0 : 1'b1;
         par  = (kind == 0) ? ~odd_par(d) : (kind == 1) ? 1'($urandom) : odd_par(d);
         exp_p = 0; exp_f = 0; exp_o = 0;
         if (!stop) exp_f = 1;
         else if ((($countones(d) + par) % 2) == 0) exp_p = 1;
         else if (model.size() == DEPTH) exp_o = 1;
         else model.push_back(d);
         p0 = perr_cnt; f0 = ferr_cnt; o0 = ovf_cnt;
         send_frame(d, par, stop, 1'b0);
         n_checks++; if (perr_cnt - p0 != exp_p || ferr_cnt - f0 != exp_f || ovf_cnt - o0 != exp_o) begin
            n_fail++; $display("FAIL rand_pulses%0d: got p/f/o=%0d/%0d/%0d want %0d/%0d/%0d", it,
               perr_cnt - p0, ferr_cnt - f0, ovf_cnt - o0, exp_p, exp_f, exp_o); end
         n_checks++; if (bus.o_count !== 4'(model.size())) begin
            n_fail++; $display("FAIL rand_count%0d: got %0d want %0d", it, bus.o_count, model.size()); end
      end
      while (model.size() > 0) begin
         x = model.pop_front();
         pop(d, e);
         n_checks++; if (e !== 1'b0 || d !== x) begin n_fail++; $display("FAIL rand_drain: got %02h empty=%b want %02h", d, e, x); end
      end
   endtask

   task automatic test_reset_midframe;
      logic [7:0] d; logic e;
      send_frame(8'h33, odd_par(8'h33), 1'b1, 1'b0);
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      n_checks++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", bus.o_busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if (bus.o_busy !== 1'b0 || bus.o_empty !== 1'b1) begin
         n_fail++; $display("FAIL mid_reset: busy=%b empty=%b want 0/1", bus.o_busy, bus.o_empty); end
      repeat (4) @(negedge clk);
      send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b0);
      pop(d, e);
      n_checks++; if (e !== 1'b0 || d !== 8'h5A) begin n_fail++; $display("FAIL mid_after: got %02h empty=%b want 5a", d, e); end
   endtask

`ifdef PS2_RX_TIMEOUT_EN
   task automatic test_timeout;
      int f0 = ferr_cnt, p0;
      logic [7:0] d; logic e;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      n_checks++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL tmo_busy_before: got %b want 1", bus.o_busy); end
      repeat (TMO + 20) @(negedge clk);
      n_checks++; if (ferr_cnt - f0 != 1 || bus.o_busy !== 1'b0) begin
         n_fail++; $display("FAIL tmo_err: pulses=%0d busy=%b want 1/0", ferr_cnt - f0, bus.o_busy); end
      f0 = ferr_cnt; p0 = perr_cnt;
      send_frame(8'h29, odd_par(8'h29), 1'b1, 1'b0);
      pop(d, e);
      n_checks++; if (e !== 1'b0 || d !== 8'h29 || ferr_cnt != f0 || perr_cnt != p0) begin
         n_fail++; $display("FAIL tmo_after: got %02h empty=%b errs=%0d want 29", d, e, (ferr_cnt - f0) + (perr_cnt - p0)); end
   endtask
`endif

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_rd_en = 1'b0;
      @(negedge clk);
      test_reset;
      test_latency;
      test_two_frames_glitch;
      test_errors;
      test_overflow;
      test_full_read_write;
      test_random;
      test_reset_midframe;
`ifdef PS2_RX_TIMEOUT_EN
      test_timeout;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
